ps2_pitch_decoder: RTL

PS2_PITCH_DECODER -- requirements
Module: ps2_pitch_decoder

---
 rtl/pitch_pkg.sv | 50 +++++
 rtl/ps2_rx.sv | 131 +++++++++++++
 rtl/ps2_pitch_decoder.sv | 85 ++++++++
 3 files changed

// File: rtl/pitch_pkg.sv
// Shared constants for the PS/2 pitch decoder: set-2 scan codes, display pitch
// codes, receiver FSM states and the scan-code-to-pitch lookup.
package pitch_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_C5    = 8'h1C;
  localparam logic [7:0] SC_D5    = 8'h1B;
  localparam logic [7:0] SC_E5    = 8'h23;
  localparam logic [7:0] SC_F5    = 8'h2B;
  localparam logic [7:0] SC_G5    = 8'h34;
  localparam logic [7:0] SC_A5    = 8'h33;
  localparam logic [7:0] SC_B5    = 8'h3B;
  localparam logic [7:0] SC_C6    = 8'h42;

  // Codes double as 7-segment glyph pairs; "05" stands in for G5.
  localparam logic [7:0] PITCH_NONE = 8'h00;
  localparam logic [7:0] PITCH_C5   = 8'hC5;
  localparam logic [7:0] PITCH_D5   = 8'hD5;
  localparam logic [7:0] PITCH_E5   = 8'hE5;
  localparam logic [7:0] PITCH_F5   = 8'hF5;
  localparam logic [7:0] PITCH_G5   = 8'h05;
  localparam logic [7:0] PITCH_A5   = 8'hA5;
  localparam logic [7:0] PITCH_B5   = 8'hB5;
  localparam logic [7:0] PITCH_C6   = 8'hC6;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic [7:0] scan_to_pitch(input logic [7:0] code);
    logic [7:0] p;
    case (code)
      SC_C5:   p = PITCH_C5;
      SC_D5:   p = PITCH_D5;
      SC_E5:   p = PITCH_E5;
      SC_F5:   p = PITCH_F5;
      SC_G5:   p = PITCH_G5;
      SC_A5:   p = PITCH_A5;
      SC_B5:   p = PITCH_B5;
      SC_C6:   p = PITCH_C6;
      default: p = PITCH_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronizers, clock glitch filter, frame FSM with
// odd-parity and stop-bit checks, and a mid-frame inactivity timeout.
module ps2_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       err
);
  import pitch_pkg::*;

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          sync_clk;
  logic          sync_data;
  logic          filt_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          differ;
  logic          settle;
  logic          fall;

  rx_state_t     state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_ok_reg, parity_ok_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  assign sync_clk  = clk_sync_reg[1];
  assign sync_data = data_sync_reg[1];

  // The filtered clock moves only once the synchronized level has disagreed
  // with it for FILTER consecutive samples; the edge is flagged in that cycle.
  assign differ = (sync_clk != filt_reg);
  assign settle = differ && (filt_cnt_reg == FW'(FILTER - 1));
  assign fall   = settle && filt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (!differ) begin
      filt_cnt_reg <= '0;
    end else if (settle) begin
      filt_reg     <= sync_clk;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + FW'(1);
    end
  end

  assign timeout = (state_reg != RX_IDLE) && !fall && (to_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RX_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_ok_reg <= 1'b0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      parity_ok_reg <= parity_ok_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    parity_ok_next = parity_ok_reg;
    to_cnt_next    = (state_reg == RX_IDLE || fall) ? '0 : to_cnt_reg + TW'(1);
    byte_valid     = 1'b0;
    err            = 1'b0;

    if (timeout) begin
      state_next  = RX_IDLE;
      shift_next  = '0;
      to_cnt_next = '0;
      err         = 1'b1;
    end else if (fall) begin
      case (state_reg)
        RX_IDLE: begin
          if (!sync_data) begin
            state_next   = RX_DATA;
            bit_cnt_next = '0;
          end
        end
        RX_DATA: begin
          shift_next   = {sync_data, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = RX_PARITY;
        end
        RX_PARITY: begin
          parity_ok_next = ^{shift_reg, sync_data};
          state_next     = RX_STOP;
        end
        RX_STOP: begin
          if (sync_data && parity_ok_reg) byte_valid = 1'b1;
          else                            err        = 1'b1;
          state_next = RX_IDLE;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  assign data_byte = shift_reg;

endmodule

// File: rtl/ps2_pitch_decoder.sv
// Turns PS/2 set-2 key make/break sequences into a held note code for a
// 7-segment display; the most recently pressed mapped key wins.
module ps2_pitch_decoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] pitch,
  output logic       byte_strobe,
  output logic       frame_err
);
  import pitch_pkg::*;

  logic [7:0] data_byte;
  logic       byte_valid;
  logic       err;
  logic [7:0] mapped;

  logic [7:0] pitch_reg, pitch_next;
  logic       brk_reg, brk_next;
  logic       ext_reg, ext_next;
  logic       strobe_reg;
  logic       err_reg;

  ps2_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (data_byte),
    .byte_valid (byte_valid),
    .err        (err)
  );

  assign mapped = scan_to_pitch(data_byte);

  always_comb begin
    pitch_next = pitch_reg;
    brk_next   = brk_reg;
    ext_next   = ext_reg;
    if (byte_valid) begin
      if (data_byte == SC_BREAK) begin
        brk_next = 1'b1;
      end else if (data_byte == SC_EXT) begin
        ext_next = 1'b1;
      end else if (ext_reg) begin
        // Extended keys are never notes; drop the key and any pending break.
        ext_next = 1'b0;
        brk_next = 1'b0;
      end else if (brk_reg) begin
        if (mapped == pitch_reg) pitch_next = PITCH_NONE;
        brk_next = 1'b0;
      end else if (mapped != PITCH_NONE) begin
        pitch_next = mapped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pitch_reg  <= PITCH_NONE;
      brk_reg    <= 1'b0;
      ext_reg    <= 1'b0;
      strobe_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      pitch_reg  <= pitch_next;
      brk_reg    <= brk_next;
      ext_reg    <= ext_next;
      strobe_reg <= byte_valid;
      err_reg    <= err;
    end
  end

  assign pitch       = pitch_reg;
  assign byte_strobe = strobe_reg;
  assign frame_err   = err_reg;

endmodule
